vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640 (visible pixels/line); H_FRONT 16 (front porch); H_SYNC 96 (sync width); H_BACK 48 (back porch).
REQ-002 SHALL have parameters: V_ACTIVE 480 (visible lines); V_FRONT 10; V_SYNC 2; V_BACK 33.
REQ-003 SHALL have parameters: CLK_DIV 4 (clk cycles per pixel, >=1); HS_POL 0 (active hsync level); VS_POL 0 (active vsync level); CW 10 (counter width).
REQ-004 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1: run enable; low freezes all timing state.
REQ-007 SHALL have port p_tick, output, 1: one-clk pixel strobe.
REQ-008 SHALL have ports hsync and vsync, output, 1 each: sync outputs at configured polarity.
REQ-009 SHALL have port video_on, output, 1: current pixel is visible.
REQ-010 SHALL have ports p_x and p_y, output, CW each: current horizontal and vertical count.
REQ-011 SHALL have ports line_start and frame_start, output, 1 each: one-clk event strobes.

Function
REQ-012 Divider SHALL count 0..CLK_DIV-1 and wrap to 0 on clk edges with en=1; with CLK_DIV=1 it SHALL be constant 0.
REQ-013 p_tick SHALL equal en AND (divider == CLK_DIV-1).
REQ-014 H counter SHALL advance only on p_tick and wrap to 0 after H_TOT-1, where H_TOT = H_ACTIVE+H_FRONT+H_SYNC+H_BACK.
REQ-015 V counter SHALL advance only on p_tick with H at H_TOT-1; it SHALL wrap to 0 after V_TOT-1, where V_TOT = sum of the V parameters.
REQ-016 hsync SHALL be at HS_POL exactly when H_ACTIVE+H_FRONT <= p_x <= H_ACTIVE+H_FRONT+H_SYNC-1, and at ~HS_POL otherwise.
REQ-017 vsync SHALL be at VS_POL exactly when V_ACTIVE+V_FRONT <= p_y <= V_ACTIVE+V_FRONT+V_SYNC-1, and at ~VS_POL otherwise.
REQ-018 video_on SHALL be (p_x < H_ACTIVE) AND (p_y < V_ACTIVE).
REQ-019 hsync, vsync and video_on SHALL be registered, computed from next-count values, and change on the same clk edge as p_x/p_y, so there is zero skew to the coordinates.
REQ-020 line_start SHALL be p_tick AND p_x==0; frame_start SHALL be p_tick AND p_x==0 AND p_y==0.
REQ-021 With en=0, divider, counters and registered outputs SHALL hold, and p_tick, line_start and frame_start SHALL be 0; resume SHALL continue from the held state.
REQ-022 Arithmetic SHALL be unsigned CW-bit; H_TOT-1 and V_TOT-1 SHALL fit in CW bits (elaboration-time check).

Reset
REQ-023 While rst=0, the divider, p_x and p_y SHALL be 0.
REQ-024 While rst=0, hsync SHALL be ~HS_POL, vsync SHALL be ~VS_POL, video_on SHALL be 1 (decode of 0,0), and p_tick/line_start/frame_start SHALL be 0.
REQ-025 Reset assertion mid-frame SHALL take effect immediately, without waiting for a clk edge.
REQ-026 The first p_tick after release SHALL occur CLK_DIV clk edges after the first edge with rst=1 and en=1.

Structure
REQ-027 The default 640x480@60 timing constants and the polarity encodings SHALL live in a shared vga_pkg, for reuse by pixel generators.
REQ-028 The clock divider SHALL be a sub-module named pix_tick_div, with parameter CLK_DIV and ports clk, rst, en, tick; the counters and decode stay in vga_timing_gen.

Verification
REQ-029 Defaults, en=1: release reset -> p_tick every 4 clks; hsync low for p_x 656..751; one frame_start per 1,680,000 clks.
REQ-030 Small config: H 4/1/2/1, V 3/1/1/1, CLK_DIV=1 -> hsync active at p_x 5..6; vsync active at p_y 4; frame_start every 48 clks; video_on for 12 of 48 clks.
REQ-031 HS_POL=1, VS_POL=1, small config -> waveforms are the exact inverse of REQ-030 on hsync/vsync; video_on and counters are unchanged.
REQ-032 Drop en for 7 clks at p_x=3, p_y=2 -> all outputs frozen and no strobes; after en returns, the sequence continues at p_x=3 with no pixel skipped or repeated.
REQ-033 Assert rst asynchronously at p_x=300, p_y=200 -> outputs at reset values before the next clk edge; after release, p_x=0, p_y=0 and timing is identical to a cold start.
REQ-034 Wrap check: p_x=799, p_y=524 plus one p_tick -> p_x=0, p_y=0, with frame_start high in that tick cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) and sync polarity encodings,
// reused by the timing generator and by downstream pixel generators.
package vga_pkg;

    localparam int H_ACTIVE_640 = 640;
    localparam int H_FRONT_640  = 16;
    localparam int H_SYNC_640   = 96;
    localparam int H_BACK_640   = 48;

    localparam int V_ACTIVE_480 = 480;
    localparam int V_FRONT_480  = 10;
    localparam int V_SYNC_480   = 2;
    localparam int V_BACK_480   = 33;

    localparam int CLK_DIV_DEF  = 4;
    localparam int CW_DEF       = 10;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_timing_gen_div.sv
// Pixel clock-enable generator: one-clk tick every CLK_DIV enabled clk edges.
module pix_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    logic [DW-1:0] divCnt;

    if (CLK_DIV < 1) begin : gBadDiv
        $error("pix_tick_div: CLK_DIV must be >= 1");
    end

    if (CLK_DIV == 1) begin : gNoDiv
        assign divCnt = '0;
    end else begin : gDiv
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                divCnt <= '0;
            end else if (en) begin
                divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + DIV_ONE;
            end
        end
    end

    // Gated by reset so a CLK_DIV=1 divider cannot strobe while held in reset.
    assign tick = rst & en & (divCnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA horizontal/vertical timing generator with registered, zero-skew
// sync and blanking outputs aligned to the p_x/p_y coordinates.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_640,
    parameter int   H_FRONT  = H_FRONT_640,
    parameter int   H_SYNC   = H_SYNC_640,
    parameter int   H_BACK   = H_BACK_640,
    parameter int   V_ACTIVE = V_ACTIVE_480,
    parameter int   V_FRONT  = V_FRONT_480,
    parameter int   V_SYNC   = V_SYNC_480,
    parameter int   V_BACK   = V_BACK_480,
    parameter int   CLK_DIV  = CLK_DIV_DEF,
    parameter logic HS_POL   = SYNC_ACTIVE_LOW,
    parameter logic VS_POL   = SYNC_ACTIVE_LOW,
    parameter int   CW       = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          p_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] p_x,
    output logic [CW-1:0] p_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if ((H_TOT > (1 << CW)) || (V_TOT > (1 << CW))) begin : gCwTooSmall
        $error("vga_timing_gen: CW too narrow for H_TOT-1 / V_TOT-1");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    function automatic logic hsyncOf(input logic [CW-1:0] x);
        return ((x >= HS_FIRST) && (x <= HS_LAST)) ? HS_POL : ~HS_POL;
    endfunction

    function automatic logic vsyncOf(input logic [CW-1:0] y);
        return ((y >= VS_FIRST) && (y <= VS_LAST)) ? VS_POL : ~VS_POL;
    endfunction

    function automatic logic visibleOf(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return (x < H_VIS) && (y < V_VIS);
    endfunction

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) uDiv (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (p_tick)
    );

    logic [CW-1:0] xNext;
    logic [CW-1:0] yNext;

    always_comb begin
        xNext = p_x + ONE;
        yNext = p_y;
        if (p_x == H_LAST) begin
            xNext = '0;
            yNext = (p_y == V_LAST) ? '0 : p_y + ONE;
        end
    end

    // Decode from next-count values so sync/blank land on the same edge as p_x/p_y.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_x      <= '0;
            p_y      <= '0;
            hsync    <= ~HS_POL;
            vsync    <= ~VS_POL;
            video_on <= 1'b1;
        end else if (p_tick) begin
            p_x      <= xNext;
            p_y      <= yNext;
            hsync    <= hsyncOf(xNext);
            vsync    <= vsyncOf(yNext);
            video_on <= visibleOf(xNext, yNext);
        end
    end

    assign line_start  = p_tick & (p_x == '0);
    assign frame_start = line_start & (p_y == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a small-geometry
// pair (active-low and active-high syncs) driven from a vector table.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] px;
        logic [9:0] py;
        logic       hs;
        logic       vs;
        logic       von;
        logic       tick;
        logic       ls;
        logic       fs;
    } outs_t;

    typedef struct {
        bit    rstn;
        bit    en;
        outs_t expS;
        outs_t expI;
    } vec_t;

    localparam int NVEC = 80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstS, enS, rstD, enD;

    logic       sTick, sHs, sVs, sVon, sLs, sFs;
    logic [9:0] sPx, sPy;
    logic       iTick, iHs, iVs, iVon, iLs, iFs;
    logic [9:0] iPx, iPy;
    logic       dTick, dHs, dVs, dVon, dLs, dFs;
    logic [9:0] dPx, dPy;

    outs_t gotS, gotI, gotD;
    assign gotS = {sPx, sPy, sHs, sVs, sVon, sTick, sLs, sFs};
    assign gotI = {iPx, iPy, iHs, iVs, iVon, iTick, iLs, iFs};
    assign gotD = {dPx, dPy, dHs, dVs, dVon, dTick, dLs, dFs};

    vga_timing_gen uDef (
        .clk (clk), .rst (rstD), .en (enD), .p_tick (dTick),
        .hsync (dHs), .vsync (dVs), .video_on (dVon), .p_x (dPx), .p_y (dPy),
        .line_start (dLs), .frame_start (dFs)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_ACTIVE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .CLK_DIV (1), .HS_POL (1'b0), .VS_POL (1'b0), .CW (10)
    ) uSmall (
        .clk (clk), .rst (rstS), .en (enS), .p_tick (sTick),
        .hsync (sHs), .vsync (sVs), .video_on (sVon), .p_x (sPx), .p_y (sPy),
        .line_start (sLs), .frame_start (sFs)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_ACTIVE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .CLK_DIV (1), .HS_POL (1'b1), .VS_POL (1'b1), .CW (10)
    ) uInv (
        .clk (clk), .rst (rstS), .en (enS), .p_tick (iTick),
        .hsync (iHs), .vsync (iVs), .video_on (iVon), .p_x (iPx), .p_y (iPy),
        .line_start (iLs), .frame_start (iFs)
    );

    int nCmp = 0;
    int nBad = 0;
    outs_t qS[$];
    outs_t qI[$];
    outs_t qD[$];
    vec_t  tbl[NVEC];

    function automatic string fmt(outs_t o);
        return $sformatf("px=%0d py=%0d hs=%b vs=%b von=%b tick=%b ls=%b fs=%b",
                         o.px, o.py, o.hs, o.vs, o.von, o.tick, o.ls, o.fs);
    endfunction

    task automatic cmp(input string name, input outs_t got, input outs_t exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got {%s} required {%s}", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic cmpInt(input string name, input int got, input int exp);
        nCmp++;
        if (got != exp) begin
            nBad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Small geometry: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), one clk per pixel.
    function automatic outs_t smallExp(int x, int y, bit rstn, bit en, bit hp, bit vp);
        outs_t o;
        o.px   = 10'(x);
        o.py   = 10'(y);
        o.tick = rstn & en;
        o.ls   = o.tick && (x == 0);
        o.fs   = o.ls && (y == 0);
        o.hs   = (x >= 5 && x <= 6) ? hp : ~hp;
        o.vs   = (y == 4) ? vp : ~vp;
        o.von  = (x < 4) && (y < 3);
        return o;
    endfunction

    // Default geometry after c enabled clk edges since reset release.
    function automatic outs_t defExp(int c);
        outs_t o;
        int x, y;
        x      = (c / 4) % 800;
        y      = ((c / 4) / 800) % 525;
        o.px   = 10'(x);
        o.py   = 10'(y);
        o.tick = (c % 4) == 3;
        o.ls   = o.tick && (x == 0);
        o.fs   = o.ls && (y == 0);
        o.hs   = (x >= 656 && x <= 751) ? 1'b0 : 1'b1;
        o.vs   = (y >= 490 && y <= 491) ? 1'b0 : 1'b1;
        o.von  = (x < 640) && (y < 480);
        return o;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mx, my, cntFs, cntVon, cntTick, cntHs, cntVs, guard;
        bit found;

        rstS = 1'b0; enS = 1'b1;
        rstD = 1'b0; enD = 1'b0;

        // Vector table: reset, run to (3,2), hold en low 7 clks, resume past a wrap.
        mx = 0; my = 0;
        for (int i = 0; i < NVEC; i++) begin
            tbl[i].rstn = (i >= 2);
            tbl[i].en   = !(i >= 21 && i <= 27);
            if (!tbl[i].rstn) begin
                mx = 0; my = 0;
            end
            tbl[i].expS = smallExp(mx, my, tbl[i].rstn, tbl[i].en, 1'b0, 1'b0);
            tbl[i].expI = smallExp(mx, my, tbl[i].rstn, tbl[i].en, 1'b1, 1'b1);
            if (tbl[i].rstn && tbl[i].en) begin
                if (mx == 7) begin
                    mx = 0;
                    my = (my == 5) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
        end

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rstS = tbl[i].rstn;
            enS  = tbl[i].en;
            qS.push_back(tbl[i].expS);
            qI.push_back(tbl[i].expI);
            #1;
            cmp($sformatf("tbl_lo[%0d]", i), gotS, qS.pop_front());
            cmp($sformatf("tbl_hi[%0d]", i), gotI, qI.pop_front());
        end

        // One full 48-clk frame window: event and level counts.
        cntFs = 0; cntVon = 0; cntTick = 0; cntHs = 0; cntVs = 0;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk); #1;
            cntFs   += int'(sFs);
            cntVon  += int'(sVon);
            cntTick += int'(sTick);
            cntHs   += int'(!sHs);
            cntVs   += int'(!sVs);
        end
        cmpInt("frame_starts_per_48", cntFs, 1);
        cmpInt("video_on_per_48", cntVon, 12);
        cmpInt("p_tick_per_48", cntTick, 48);
        cmpInt("hsync_active_per_48", cntHs, 12);
        cmpInt("vsync_active_per_48", cntVs, 8);

        // Wrap: (7,5) plus one tick lands on (0,0) with frame_start.
        found = 1'b0;
        for (guard = 0; guard < 60 && !found; guard++) begin
            @(negedge clk); #1;
            if (sPx == 10'd7 && sPy == 10'd5) found = 1'b1;
        end
        cmpInt("wrap_reached", int'(found), 1);
        @(negedge clk); #1;
        cmpInt("wrap_px", int'(sPx), 0);
        cmpInt("wrap_py", int'(sPy), 0);
        cmpInt("wrap_frame_start", int'(sFs), 1);
        cmpInt("wrap_frame_start_hi", int'(iFs), 1);

        // Asynchronous reset mid-frame, then cold-start replay.
        found = 1'b0;
        for (guard = 0; guard < 60 && !found; guard++) begin
            @(negedge clk); #1;
            if (sPx == 10'd3 && sPy == 10'd2) found = 1'b1;
        end
        cmpInt("mid_frame_reached", int'(found), 1);
        #2;
        rstS = 1'b0;
        #1;
        cmp("async_rst_lo", gotS, smallExp(0, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        cmp("async_rst_hi", gotI, smallExp(0, 0, 1'b0, 1'b1, 1'b1, 1'b1));
        @(negedge clk);
        @(negedge clk);
        rstS = 1'b1;
        for (int t = 0; t < 20; t++) begin
            qS.push_back(smallExp(t % 8, (t / 8) % 6, 1'b1, 1'b1, 1'b0, 1'b0));
            #1;
            cmp($sformatf("cold_start[%0d]", t), gotS, qS.pop_front());
            @(negedge clk);
        end

        // Default geometry: reset state, then a line and a bit with en held high.
        rstD = 1'b0; enD = 1'b1;
        #1;
        cmp("def_reset", gotD, '{px: 10'd0, py: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b1,
                                 tick: 1'b0, ls: 1'b0, fs: 1'b0});
        @(negedge clk);
        rstD = 1'b1;
        for (int c = 0; c < 3300; c++) begin
            qD.push_back(defExp(c));
            #1;
            cmp($sformatf("def[%0d]", c), gotD, qD.pop_front());
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
